instr_loader: RTL and testbench

//   Byte-stream program loader that drives the CPU instruction-write interface (wr_instr_en_i/wr_instr_i).

---
 rtl/instr_loader.sv | 147 ++++++++++++++
 tb/tb_instr_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream program loader: takes a length-prefixed little-endian byte stream, emits one
// instruction write strobe per assembled 32-bit word and holds the CPU in reset until the load completes.
module instr_loader #(
    parameter int MAX_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wr_instr_en_o,
    output logic [31:0] wr_instr_o,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] word_count_o,
    output logic [2:0]  state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q;
    logic [31:0]   word_q;
    logic [31:0]   wr_q;
    logic [1:0]    byte_idx_q;
    logic [TW-1:0] tmo_q;
    logic [15:0]   word_cnt_q;

    logic          counting;
    logic          accept;
    logic          tmo_hit;
    logic          restart;
    logic [15:0]   len_n;

    // A byte transfers on a rising edge where byte_valid_i && byte_ready_o; ready is a pure
    // decode of the registered state and never looks at byte_valid_i.
    assign counting = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign accept   = byte_valid_i && byte_ready_o;
    assign tmo_hit  = counting && !accept && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign restart  = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign len_n    = {byte_data_i, len_q[7:0]};

    assign byte_ready_o  = counting;
    assign busy_o        = counting || (state_q == WRITE);
    assign wr_instr_en_o = (state_q == WRITE);
    assign wr_instr_o    = wr_q;
    assign cpu_rst_o     = (state_q != DONE);
    assign done_o        = (state_q == DONE);
    assign err_o         = (state_q == ERR);
    assign word_count_o  = word_cnt_q;
    assign state_o       = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (accept)       state_d = LEN_HI;
                else if (tmo_hit) state_d = ERR;
            end
            LEN_HI: begin
                if (accept) begin
                    if (len_n == 16'd0 || len_n > 16'(MAX_WORDS)) state_d = ERR;
                    else                                          state_d = DATA;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (accept) begin
                    if (byte_idx_q == 2'd3) state_d = WRITE;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            WRITE: begin
                if (word_cnt_q + 16'd1 == len_q) state_d = DONE;
                else                             state_d = DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q      <= '0;
            word_q     <= '0;
            wr_q       <= '0;
            byte_idx_q <= '0;
            tmo_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            if (restart) begin
                // Fresh session: any stale partial word from an aborted load is dropped here.
                tmo_q      <= '0;
                byte_idx_q <= '0;
                word_cnt_q <= '0;
            end else if (counting) begin
                if (accept) tmo_q <= '0;
                else        tmo_q <= tmo_q + TW'(1);
            end

            if (accept) begin
                case (state_q)
                    LEN_LO: len_q[7:0] <= byte_data_i;
                    LEN_HI: begin
                        len_q[15:8] <= byte_data_i;
                        byte_idx_q  <= '0;
                    end
                    DATA: begin
                        word_q[{byte_idx_q, 3'b000} +: 8] <= byte_data_i;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) wr_q <= {byte_data_i, word_q[23:0]};
                    end
                    default: ;
                endcase
            end

            if (state_q == WRITE) word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: length framing, word assembly, write strobes, error paths,
// timeout and asynchronous reset, checked with immediate assertions.
module tb_instr_loader;

    localparam int MAXW = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_instr;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;
    logic [2:0]  state;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;
    logic [31:0] exp_q[$];

    instr_loader #(.MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
        .wr_instr_en_o(wr_en), .wr_instr_o(wr_instr), .cpu_rst_o(cpu_rst),
        .busy_o(busy), .done_o(done), .err_o(err), .word_count_o(word_count), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every strobe must match the next word the bench queued; a strobe with nothing queued is an error.
    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            strobes++;
            if (exp_q.size() == 0) chk("unexpected_strobe", wr_instr, 32'hxxxx_xxxx);
            else                   chk("strobe_word", wr_instr, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep_valid);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("ready_wait", {31'd0, byte_ready}, 32'd1);
        tick();
        if (!keep_valid) byte_valid = 1'b0;
    endtask

    task automatic send_len(input logic [15:0] n, input bit keep_valid);
        send_byte(n[7:0], keep_valid);
        send_byte(n[15:8], keep_valid);
    endtask

    task automatic send_word(input logic [31:0] w, input bit keep_valid);
        exp_q.push_back(w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], keep_valid);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        #1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset values
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_instr", wr_instr, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_count", {16'd0, word_count}, 32'd0);
        chk("rst_state", {29'd0, state}, 32'd0);

        // Two-word program; strobe appears the cycle right after each 4th byte
        start_pulse();
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_ready", {31'd0, byte_ready}, 32'd1);
        send_len(16'd2, 1'b0);
        send_word(32'h0010_0513, 1'b0);
        chk("t2_w0_en", {31'd0, wr_en}, 32'd1);
        chk("t2_w0_instr", wr_instr, 32'h0010_0513);
        chk("t2_w0_ready", {31'd0, byte_ready}, 32'd0);
        send_word(32'h0020_0593, 1'b0);
        chk("t2_w1_en", {31'd0, wr_en}, 32'd1);
        chk("t2_w1_instr", wr_instr, 32'h0020_0593);
        tick();
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("t2_count", {16'd0, word_count}, 32'd2);
        chk("t2_busy_end", {31'd0, busy}, 32'd0);
        chk("t2_hold_instr", wr_instr, 32'h0020_0593);
        chk("t2_en_low", {31'd0, wr_en}, 32'd0);

        // Valid held high throughout; WRITE cycles must back-pressure
        start_pulse();
        chk("t3_cpu_rst_reassert", {31'd0, cpu_rst}, 32'd1);
        chk("t3_done_clr", {31'd0, done}, 32'd0);
        send_len(16'd2, 1'b1);
        send_word(32'hdead_beef, 1'b1);
        chk("t3_w0_ready", {31'd0, byte_ready}, 32'd0);
        chk("t3_w0_valid", {31'd0, byte_valid}, 32'd1);
        send_word(32'h1234_5678, 1'b1);
        chk("t3_w1_ready", {31'd0, byte_ready}, 32'd0);
        tick();
        byte_valid = 1'b0;
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_count", {16'd0, word_count}, 32'd2);

        // Zero length and MAX_WORDS+1 both abort before any data
        start_pulse();
        send_len(16'd0, 1'b0);
        chk("t4_zero_err", {31'd0, err}, 32'd1);
        chk("t4_zero_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("t4_zero_busy", {31'd0, busy}, 32'd0);
        start_pulse();
        chk("t4_err_clr", {31'd0, err}, 32'd0);
        send_len(16'(MAXW + 1), 1'b0);
        chk("t4_over_err", {31'd0, err}, 32'd1);
        chk("t4_over_count", {16'd0, word_count}, 32'd0);
        chk("t4_over_ready", {31'd0, byte_ready}, 32'd0);

        // Exactly MAX_WORDS is legal
        start_pulse();
        send_len(16'(MAXW), 1'b0);
        for (int i = 0; i < MAXW; i++) send_word(32'h1000_0000 + i, 1'b0);
        tick();
        chk("t4_max_done", {31'd0, done}, 32'd1);
        chk("t4_max_count", {16'd0, word_count}, 32'(MAXW));

        // Stall after two data bytes: ERR exactly on the 16th idle cycle, partial word dropped
        start_pulse();
        send_len(16'd1, 1'b0);
        send_byte(8'haa, 1'b0);
        send_byte(8'hbb, 1'b0);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("t5_pre_err", {31'd0, err}, 32'd0);
        chk("t5_pre_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_err_count", {16'd0, word_count}, 32'd0);
        chk("t5_err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        start_pulse();
        send_len(16'd1, 1'b0);
        send_word(32'h0bad_f00d, 1'b0);
        tick();
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_err_clr", {31'd0, err}, 32'd0);
        chk("t5_count", {16'd0, word_count}, 32'd1);

        // start_i during DATA is ignored: the word completes as if it never happened
        start_pulse();
        send_len(16'd1, 1'b0);
        exp_q.push_back(32'h0123_4567);
        send_byte(8'h67, 1'b0);
        send_byte(8'h45, 1'b0);
        start_pulse();
        chk("t6_ign_busy", {31'd0, busy}, 32'd1);
        chk("t6_ign_ready", {31'd0, byte_ready}, 32'd1);
        send_byte(8'h23, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("t6_ign_en", {31'd0, wr_en}, 32'd1);
        tick();
        chk("t6_ign_done", {31'd0, done}, 32'd1);

        // Asynchronous reset mid-word: reset values before the next edge, no strobe
        start_pulse();
        send_len(16'd1, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("t6_rst_count", {16'd0, word_count}, 32'd0);
        chk("t6_rst_instr", wr_instr, 32'd0);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h44;
        tick(); tick(); tick();
        byte_valid = 1'b0;
        chk("t6_post_state", {29'd0, state}, 32'd0);
        chk("t6_post_en", {31'd0, wr_en}, 32'd0);

        chk("total_strobes", strobes, 32'd10);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
